// File: rtl/receiver_pkg.sv
// Shared definitions for the receiver: handshake FSM encodings and default sizing.
package receiver_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

endpackage

// File: rtl/receiver_rcv_fifo.sv
// First-word-fall-through FIFO; head visible the cycle after a push, 0 when empty.
// Push is refused when full and pop is ignored when empty; Count never over/underflows.
module rcv_fifo #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  pop_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage is deliberately left out of reset; only pointers and count matter.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/receiver.sv
// Request/Ack word receiver: captures on the Request edge, Ack one cycle later, buffers in a FIFO.
// Backpressure: Ack is withheld while the FIFO is full, so no word is ever dropped.
module receiver
    import receiver_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Request,
    input  logic [WIDTH-1:0]  rcvDataIn,
    output logic              Ack,
    output logic              Busy,
    output logic              Valid,
    input  logic              Read,
    output logic [WIDTH-1:0]  rcvDataOut,
    output logic [ADDR_W:0]   Count
);

    state_t state;
    state_t state_nxt;
    logic   push;
    logic   full;
    logic   empty;

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state <= WAIT_LOW;
        end else begin
            state <= state_nxt;
        end
    end

    // Fullness is the registered count, so a same-cycle pop cannot enable a push.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (Request && !full) begin
                    push      = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!Request) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = WAIT_LOW;
            end
        endcase
    end

    assign Ack   = (state == ACK);
    assign Busy  = (state != IDLE);
    assign Valid = !empty;

    rcv_fifo #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .Reset     (Reset),
        .push      (push),
        .push_data (rcvDataIn),
        .pop       (Read),
        .pop_data  (rcvDataOut),
        .full      (full),
        .empty     (empty),
        .count     (Count)
    );

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: handshake, backpressure, FIFO ordering and reset abort.
module tb_receiver;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Request;
    logic [15:0] rcvDataIn;
    logic        Ack;
    logic        Busy;
    logic        Valid;
    logic        Read;
    logic [15:0] rcvDataOut;
    logic [2:0]  Count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    receiver dut (
        .clk        (clk),
        .Reset      (Reset),
        .Request    (Request),
        .rcvDataIn  (rcvDataIn),
        .Ack        (Ack),
        .Busy       (Busy),
        .Valid      (Valid),
        .Read       (Read),
        .rcvDataOut (rcvDataOut),
        .Count      (Count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full handshake from IDLE; optionally checks the head word right after capture.
    task automatic send(input logic [15:0] d, input logic chk_head);
        logic got;
        got       = 1'b0;
        Request   = 1'b1;
        rcvDataIn = d;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (Ack) got = 1'b1;
        end
        check("send_ack", {31'd0, got}, 32'd1);
        if (chk_head) begin
            check("head_data", {16'd0, rcvDataOut}, {16'd0, d});
            check("head_count", {29'd0, Count}, 32'd1);
        end
        Request   = 1'b0;
        rcvDataIn = 16'hdead;
        tick();
        check("ack_pulse", {31'd0, Ack}, 32'd0);
        tick();
    endtask

    initial begin
        int acks;
        Reset     = 1'b0;
        Request   = 1'b1;
        rcvDataIn = 16'h0bad;
        Read      = 1'b0;

        // Reset held with Request high, then released with Request still high.
        tick();
        tick();
        check("rst_ack", {31'd0, Ack}, 32'd0);
        check("rst_count", {29'd0, Count}, 32'd0);
        check("rst_valid", {31'd0, Valid}, 32'd0);
        check("rst_dout", {16'd0, rcvDataOut}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd1);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_req_ack", {31'd0, Ack}, 32'd0);
            check("held_req_count", {29'd0, Count}, 32'd0);
        end
        Request = 1'b0;
        tick();
        check("idle_busy", {31'd0, Busy}, 32'd0);

        // First word after reset.
        send(16'h0010, 1'b1);
        check("first_valid", {31'd0, Valid}, 32'd1);
        Read = 1'b1;
        tick();
        Read = 1'b0;
        check("first_drain", {29'd0, Count}, 32'd0);

        // 17 words streamed through with Read held; pointers wrap several times.
        Read = 1'b1;
        for (int w = 0; w < 17; w++) begin
            send(16'h0010 + 16'(w), 1'b1);
            check("stream_count", {29'd0, Count}, 32'd0);
        end
        Read = 1'b0;

        // Request held high: exactly one capture, FSM parks in WAIT_LOW.
        Request   = 1'b1;
        rcvDataIn = 16'h00aa;
        tick();
        check("hold_ack", {31'd0, Ack}, 32'd1);
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (Ack) acks++;
        end
        check("hold_extra_acks", 32'(acks), 32'd0);
        check("hold_count", {29'd0, Count}, 32'd1);
        check("hold_busy", {31'd0, Busy}, 32'd1);
        Request = 1'b0;
        tick();
        check("hold_release_busy", {31'd0, Busy}, 32'd0);
        Read = 1'b1;
        tick();
        Read = 1'b0;
        check("hold_drain", {29'd0, Count}, 32'd0);

        // Fill to DEPTH, fifth request must stall until a pop frees space.
        for (int w = 0; w < 4; w++) send(16'h0010 + 16'(w), 1'b0);
        check("full_count", {29'd0, Count}, 32'd4);
        Request   = 1'b1;
        rcvDataIn = 16'h0014;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_no_ack", {31'd0, Ack}, 32'd0);
        end
        check("full_head", {16'd0, rcvDataOut}, 32'h0010);
        Read = 1'b1;
        tick();
        Read = 1'b0;
        check("pop_when_full_ack", {31'd0, Ack}, 32'd0);
        check("pop_when_full_count", {29'd0, Count}, 32'd3);
        tick();
        check("late_push_ack", {31'd0, Ack}, 32'd1);
        check("late_push_count", {29'd0, Count}, 32'd4);
        Request = 1'b0;
        tick();
        tick();
        for (int w = 1; w < 5; w++) begin
            check("drain_order", {16'd0, rcvDataOut}, {16'd0, 16'h0010 + 16'(w)});
            Read = 1'b1;
            tick();
            Read = 1'b0;
        end
        check("drain_count", {29'd0, Count}, 32'd0);
        check("drain_valid", {31'd0, Valid}, 32'd0);

        // Read on empty FIFO is ignored.
        Read = 1'b1;
        tick();
        Read = 1'b0;
        check("empty_read_count", {29'd0, Count}, 32'd0);
        check("empty_read_valid", {31'd0, Valid}, 32'd0);
        check("empty_dout", {16'd0, rcvDataOut}, 32'd0);

        // Simultaneous push and pop with two words stored.
        send(16'h0021, 1'b0);
        send(16'h0022, 1'b0);
        check("two_count", {29'd0, Count}, 32'd2);
        Request   = 1'b1;
        rcvDataIn = 16'h0023;
        Read      = 1'b1;
        tick();
        Read = 1'b0;
        check("pushpop_ack", {31'd0, Ack}, 32'd1);
        check("pushpop_count", {29'd0, Count}, 32'd2);
        check("pushpop_head", {16'd0, rcvDataOut}, 32'h0022);
        Request = 1'b0;
        tick();
        tick();

        // Reset during ACK aborts the handshake and clears the FIFO.
        Request   = 1'b1;
        rcvDataIn = 16'h0030;
        tick();
        check("pre_abort_ack", {31'd0, Ack}, 32'd1);
        Reset = 1'b0;
        tick();
        check("abort_ack", {31'd0, Ack}, 32'd0);
        check("abort_count", {29'd0, Count}, 32'd0);
        check("abort_valid", {31'd0, Valid}, 32'd0);
        Reset   = 1'b1;
        Request = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
- Far end of the sender's Request/Ack word handshake.
- Captures each 16-bit word the sender presents with Request, acknowledges it with a one-cycle Ack pulse, and buffers it in a small FIFO for a local consumer.
- Exerts backpressure by withholding Ack while the FIFO is full, so no word is ever dropped.

Parameters:
- WIDTH, 16, data word width; must match the sender's data width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- Request  input  1  sender has a valid word on rcvDataIn.
- rcvDataIn  input  WIDTH  word from the sender; valid while Request=1.
- Ack  output  1  one-cycle acknowledge: the word has been captured.
- Busy  output  1  handshake FSM is not in IDLE.
- Valid  output  1  FIFO not empty; rcvDataOut holds the oldest word.
- Read  input  1  consumer pops the head word when Valid=1.
- rcvDataOut  output  WIDTH  FIFO head (first-word-fall-through); 0 when empty.
- Count  output  ADDR_W+1  number of stored words, 0..DEPTH.

Behaviour:
- Reset (Reset=0 at an edge):
  - state <= WAIT_LOW; Ack=0; FIFO pointers and Count cleared.
  - Valid=0, rcvDataOut=0; FIFO storage itself is not reset.
  - Reset overrides every other event in that cycle.
  - Mid-handshake reset aborts the transfer: Ack is 0 after the edge.
  - A Request still high when Reset is released is not captured; the FSM waits for Request=0 first.
- FSM states: IDLE, ACK, WAIT_LOW. State is registered; Ack is Moore (Ack=1 iff state==ACK).
  - IDLE: if Request=1 and Count<DEPTH: push rcvDataIn at this edge, go to ACK. Otherwise stay.
  - ACK: unconditionally go to WAIT_LOW. Ack is high for exactly one cycle.
  - WAIT_LOW: if Request=0, go to IDLE; else stay. This prevents double capture of a held Request.
- Timing and throughput:
  - Latency: Request sampled high at edge N gives Ack=1 from edge N to edge N+1, and Valid=1 from edge N.
  - Minimum 3 cycles per word when Request drops right after Ack.
- Full (Count==DEPTH):
  - IDLE does not capture and Ack stays 0 until a pop frees space.
  - Fullness is evaluated before any same-cycle pop, so a simultaneous pop does not enable a push; the push occurs the next cycle.
- Read:
  - Pop when Read=1 and Valid=1. Read with Valid=0 is ignored: no pointer or Count change.
- Simultaneous push and pop (not full, not empty): both occur and Count is unchanged.
- Pointers are ADDR_W bits and wrap modulo DEPTH. Count is updated +1, -1 or 0 per cycle and never exceeds DEPTH or underflows.
- rcvDataIn is sampled only on the capture edge; changes at any other time are ignored.
- Busy = (state != IDLE).

Decomposition:
- Shared header receiver_defs: FSM state encodings (IDLE=2'd0, ACK=2'd1, WAIT_LOW=2'd2) and the default WIDTH/DEPTH.
- Sub-module rcv_fifo holds storage, pointers and Count, with push/pop/full/empty interface and the same clk/Reset.
- The top level holds the FSM plus glue logic.

Test Plan:
- Reset held with Request=1, then released → Ack stays 0 and Count=0 until Request drops; the next Request with 16'h0010 produces a 1-cycle Ack and rcvDataOut=16'h0010, Valid=1.
- 17 words 16'h0010..16'h0020, one per handshake, with Read held 1 → 17 Ack pulses; rcvDataOut sequence 0010..0020 in order; Count never exceeds 1; pointers wrap correctly.
- Request held high continuously with one word → exactly one Ack and Count=1; the FSM stays in WAIT_LOW until Request=0.
- Read=0 while 5 words are offered with DEPTH=4 → 4 Acks, Count=4, 5th Request pending with no Ack. Then Read=1 for one cycle → pop of 16'h0010; the 5th word is captured the following cycle and Ack pulses.
- Read=1 with FIFO empty → Count stays 0 and Valid stays 0. With Count=2, a push and pop in the same cycle → Count stays 2.
- Reset asserted during the ACK state → Ack=0, Count=0 and Valid=0 after that edge.
